// File: rtl/inside_run_detector.sv
// Range-membership run detector: counts accepted codes inside [LO:HI] and raises
// a valid/ready event after RUN_LEN consecutive hits. Optional macro: INSIDE_RUN_OVERLAP_EN.
module inside_run_detector #(
  parameter int unsigned W       = 3,
  parameter int unsigned LO      = 4,
  parameter int unsigned HI      = 6,
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_code,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] hit_total,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   hit_total_q, hit_total_d;
  logic               evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0]   evt_count_q, evt_count_d;

  logic               accept;
  logic               hit;
  logic [CNT_W-1:0]   run_cnt_inc;
  logic [CNT_W-1:0]   hit_total_inc;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign hit       = (in_code >= W'(LO)) && (in_code <= W'(HI));
  assign busy      = (run_cnt_q != '0) || (state_q == HOLD);
  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;
  assign hit_total = hit_total_q;

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    hit_total_d   = hit_total_q;
    evt_valid_d   = evt_valid_q;
    evt_count_d   = evt_count_q;
    run_cnt_inc   = run_cnt_q + CNT_W'(1);
    // Saturate rather than wrap once the counter is all ones.
    hit_total_inc = (&hit_total_q) ? hit_total_q : hit_total_q + CNT_W'(1);

    unique case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (hit) begin
            hit_total_d = hit_total_inc;
            run_cnt_d   = run_cnt_inc;
            if (run_cnt_inc == CNT_W'(RUN_LEN)) begin
              state_d     = HOLD;
              evt_valid_d = 1'b1;
              evt_count_d = hit_total_inc;
            end else begin
              state_d = RUN;
            end
          end else begin
            run_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
`ifdef INSIDE_RUN_OVERLAP_EN
          // Keep the last RUN_LEN-1 hits so the next hit can fire again.
          run_cnt_d = CNT_W'(RUN_LEN - 1);
          state_d   = (RUN_LEN == 1) ? IDLE : RUN;
`else
          run_cnt_d = '0;
          state_d   = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      hit_total_q <= '0;
      evt_valid_q <= 1'b0;
      evt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      hit_total_q <= hit_total_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
    end
  end

endmodule

// File: tb/tb_inside_run_detector.sv
// Scoreboard bench for inside_run_detector: a default instance and a CNT_W=3
// instance; expected event payloads are queued and popped on each handshake.
module tb_inside_run_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, evt_valid, evt_ready, busy;
  logic [2:0] in_code;
  logic [7:0] evt_count, hit_total;

  logic       s_in_valid, s_in_ready, s_evt_valid, s_evt_ready, s_busy;
  logic [2:0] s_in_code;
  logic [2:0] s_evt_count, s_hit_total;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp_sq[$];

  always #5 clk = ~clk;

  inside_run_detector u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
    .hit_total(hit_total), .busy(busy)
  );

  inside_run_detector #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code),
    .evt_valid(s_evt_valid), .evt_ready(s_evt_ready), .evt_count(s_evt_count),
    .hit_total(s_hit_total), .busy(s_busy)
  );

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitors: pop one expected payload per completed event handshake.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("unexpected_evt", int'(evt_count), -1);
      else check("evt_count", int'(evt_count), exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_evt_valid && s_evt_ready) begin
      if (exp_sq.size() == 0) check("unexpected_sat_evt", int'(s_evt_count), -1);
      else check("sat_evt_count", int'(s_evt_count), exp_sq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Present one code and return at #1 after the edge that accepted it.
  task automatic send(input logic [2:0] c);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
      if (!acc && n > 20) begin
        check("send_timeout", n, 0);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [2:0] c);
    bit acc = 1'b0;
    int n = 0;
    s_in_valid = 1'b1;
    s_in_code  = c;
    while (!acc) begin
      @(negedge clk);
      acc = s_in_ready;
      step();
      n++;
      if (!acc && n > 20) begin
        check("send_s_timeout", n, 0);
        acc = 1'b1;
      end
    end
    s_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_code = '0; evt_ready = 1'b0;
    s_in_valid = 1'b0; s_in_code = '0; s_evt_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset values
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_hit_total", int'(hit_total), 0);
    check("rst_evt_count", int'(evt_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Basic run 4,5,6 with downstream ready
    evt_ready = 1'b1;
    exp_q.push_back(3);
    send(3'd4); send(3'd5); send(3'd6);
    check("run_evt_valid", int'(evt_valid), 1);
    check("run_evt_count", int'(evt_count), 3);
    check("run_hit_total", int'(hit_total), 3);
    step();
    check("run_evt_one_cycle", int'(evt_valid), 0);
    check("run_in_ready_back", int'(in_ready), 1);

    // Broken run: 4,5,3,6,6,6
    do_reset();
    exp_q.push_back(5);
    send(3'd4); send(3'd5);
    check("brk_no_evt", int'(evt_valid), 0);
    send(3'd3);
    check("brk_busy_cleared", int'(busy), 0);
    send(3'd6); send(3'd6);
    check("brk_no_evt2", int'(evt_valid), 0);
    send(3'd6);
    check("brk_evt_valid", int'(evt_valid), 1);
    step();
    check("brk_hit_total", int'(hit_total), 5);

    // Backpressure: event held while input keeps offering code 5
    do_reset();
    evt_ready = 1'b0;
    exp_q.push_back(3);
    send(3'd6); send(3'd6); send(3'd6);
    in_valid = 1'b1;
    in_code  = 3'd5;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_evt_valid", int'(evt_valid), 1);
      check("bp_evt_count", int'(evt_count), 3);
      check("bp_hit_total", int'(hit_total), 3);
      step();
    end
    in_valid  = 1'b0;
    evt_ready = 1'b1;
    check("bp_evt_before_hs", int'(evt_valid), 1);
    step();
    check("bp_evt_after_hs", int'(evt_valid), 0);
    check("bp_in_ready_after", int'(in_ready), 1);
    check("bp_hit_total_after", int'(hit_total), 3);

    // Asynchronous reset while an event is pending
    do_reset();
    evt_ready = 1'b0;
    send(3'd4); send(3'd4); send(3'd4);
    check("ar_evt_pending", int'(evt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_evt_valid", int'(evt_valid), 0);
    check("ar_hit_total", int'(hit_total), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // Range boundaries and idle gaps inside a run
    evt_ready = 1'b1;
    send(3'd3); send(3'd7); send(3'd0);
    check("bnd_misses", int'(hit_total), 0);
    check("bnd_busy_idle", int'(busy), 0);
    exp_q.push_back(3);
    send(3'd4);
    check("bnd_lo_hit", int'(hit_total), 1);
    check("bnd_busy_run", int'(busy), 1);
    step(); step();
    send(3'd6);
    check("bnd_hi_hit", int'(hit_total), 2);
    step(); step(); step();
    send(3'd4);
    check("gap_evt_valid", int'(evt_valid), 1);
    step();

    // Saturating counter on the narrow instance
    s_evt_ready = 1'b1;
`ifdef INSIDE_RUN_OVERLAP_EN
    exp_sq.push_back(3); exp_sq.push_back(4); exp_sq.push_back(5);
    for (int i = 0; i < 5; i++) send_s(3'd5);
    step();
    check("sat_hit_total", int'(s_hit_total), 5);
`else
    exp_sq.push_back(3); exp_sq.push_back(6); exp_sq.push_back(7);
    for (int i = 0; i < 10; i++) send_s(3'd5);
    step();
    check("sat_hit_total", int'(s_hit_total), 7);
`endif

    step(); step();
    check("evt_q_drained", exp_q.size(), 0);
    check("sat_q_drained", exp_sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
